vga_test_pattern: RTL and testbench

- Generates standard 640x480 @ 60 Hz VGA timing from the 50 MHz board clock and drives a fixed eight-bar colour test pattern to an ADV7123-style video DAC.
- Serves as a bring-up and test block for the VGA output path.
- Exports horizontal and vertical timing-phase codes as debug outputs.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_axis_counter.sv | 81 ++++++++
 rtl/vga_test_pattern.sv | 157 +++++++++++++++
 tb/tb_vga_test_pattern.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator.
// Holds the 640x480@60 timing constants, derived line/frame totals, the
// timing-phase encoding exported on the debug outputs and the colour-bar table.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    localparam int BAR_W    = 80;

    // Timing-phase code; values 4..7 are never produced
    typedef enum logic [2:0] {
        PH_ACTIVE = 3'd0,
        PH_FRONT  = 3'd1,
        PH_SYNC   = 3'd2,
        PH_BACK   = 3'd3
    } phase_e;

    // Colour bars packed as 24-bit {R,G,B}; bar 0 sits in the least significant slot
    localparam logic [8*24-1:0] BAR_LUT = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

    // Colour of one bar, {R,G,B}
    function automatic logic [23:0] bar_colour(input logic [2:0] bar);
        return BAR_LUT[24*int'(bar) +: 24];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the VGA raster.
// Counts 0..TOTAL-1 on each enabled cycle and reports which timing phase the
// count lies in. The phase is registered together with the count, so both
// always describe the same position.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : advance the count by one on this cycle
//   count      : current position on the axis
//   phase      : ACTIVE / FRONT / SYNC / BACK code for count
//   wrap       : high on the enabled cycle that takes count from TOTAL-1 to 0
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output phase_e        phase,
    output logic          wrap
);

    localparam int            TOTAL  = ACTIVE + FP + SYNC + BP;
    localparam logic [CW-1:0] LAST_C = CW'(TOTAL - 1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    phase_e        phase_r;
    phase_e        phase_nxt_s;
    logic          last_s;

    // Phase boundaries are cumulative sums of the region widths
    function automatic phase_e phase_of(input logic [CW-1:0] c);
        if (int'(c) < ACTIVE) begin
            return PH_ACTIVE;
        end else if (int'(c) < ACTIVE + FP) begin
            return PH_FRONT;
        end else if (int'(c) < ACTIVE + FP + SYNC) begin
            return PH_SYNC;
        end else begin
            return PH_BACK;
        end
    endfunction

    // Next count (wrapping at TOTAL-1) and the phase that goes with it
    always_comb begin
        last_s      = (count_r == LAST_C);
        count_nxt_s = count_r;
        if (en) begin
            if (last_s) begin
                count_nxt_s = {CW{1'b0}};
            end else begin
                count_nxt_s = count_r + CW'(1);
            end
        end else begin
            count_nxt_s = count_r;
        end
        phase_nxt_s = phase_of(count_nxt_s);
    end

    // Count and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
            phase_r <= PH_ACTIVE;
        end else begin
            count_r <= count_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

    assign count = count_r;
    assign phase = phase_r;
    assign wrap  = en & last_s;

endmodule

// File: rtl/vga_test_pattern.sv
// VGA bring-up block: 640x480@60 timing from the 50 MHz clock with an
// eight-bar colour pattern for an ADV7123-style DAC.
// The pixel clock is CLOCK_50/2. Every output except VGA_CLK and VGA_SYNC_N
// is registered on the CLOCK_50 edge where VGA_CLK falls, so the DAC sees
// stable data on the VGA_CLK rising edge; all of them lag the counters by one
// pixel step.
// Ports:
//   CLOCK_50, RESET_N     : 50 MHz clock, asynchronous active-low reset
//   VGA_R/G/B             : 8-bit colour data, forced to 0 while blanked
//   VGA_CLK               : 25 MHz pixel clock
//   VGA_SYNC_N            : sync-on-green control, tied low
//   VGA_BLANK_N           : high only inside the visible region
//   VGA_HS, VGA_VS        : active-low syncs
//   ohs, ovs              : horizontal / vertical timing-phase codes
module vga_test_pattern #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int BAR_W    = vga_pkg::BAR_W
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_CLK,
    output logic       VGA_SYNC_N,
    output logic       VGA_BLANK_N,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [2:0] ohs,
    output logic [2:0] ovs
);

    import vga_pkg::*;

    localparam int HCW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VCW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    logic           pix_clk_r;
    logic           step_s;
    logic [HCW-1:0] h_count_s;
    phase_e         h_phase_s;
    logic           h_wrap_s;
    logic [VCW-1:0] v_count_s;
    phase_e         v_phase_s;
    logic           v_wrap_s;
    logic           unused_s;

    logic [2:0]     bar_s;
    logic           hs_nxt_s;
    logic           vs_nxt_s;
    logic           blank_n_nxt_s;
    logic [23:0]    rgb_nxt_s;

    logic           hs_r;
    logic           vs_r;
    logic           blank_n_r;
    logic [23:0]    rgb_r;
    logic [2:0]     ohs_r;
    logic [2:0]     ovs_r;

    // Pixel-clock divider: toggles on every CLOCK_50 edge
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_clk_r <= 1'b0;
        end else begin
            pix_clk_r <= ~pix_clk_r;
        end
    end

    // A pixel step is the edge on which the pixel clock falls
    assign step_s = pix_clk_r;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CW     (HCW)
    ) u_h_counter (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .en     (step_s),
        .count  (h_count_s),
        .phase  (h_phase_s),
        .wrap   (h_wrap_s)
    );

    // Lines advance on the pixel step that ends a line
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CW     (VCW)
    ) u_v_counter (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .en     (h_wrap_s),
        .count  (v_count_s),
        .phase  (v_phase_s),
        .wrap   (v_wrap_s)
    );

    // Only the vertical phase is needed; its count and wrap are left unused
    assign unused_s = ^{v_count_s, v_wrap_s};

    // Decode syncs, blanking and bar colour from the current raster position
    always_comb begin
        bar_s         = 3'(h_count_s / HCW'(BAR_W));
        hs_nxt_s      = (h_phase_s != PH_SYNC);
        vs_nxt_s      = (v_phase_s != PH_SYNC);
        blank_n_nxt_s = (h_phase_s == PH_ACTIVE) && (v_phase_s == PH_ACTIVE);
        if (blank_n_nxt_s) begin
            rgb_nxt_s = bar_colour(bar_s);
        end else begin
            rgb_nxt_s = 24'h000000;
        end
    end

    // Output registers, all updated together on the pixel step
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
            rgb_r     <= 24'h000000;
            ohs_r     <= 3'd0;
            ovs_r     <= 3'd0;
        end else if (step_s) begin
            hs_r      <= hs_nxt_s;
            vs_r      <= vs_nxt_s;
            blank_n_r <= blank_n_nxt_s;
            rgb_r     <= rgb_nxt_s;
            ohs_r     <= h_phase_s;
            ovs_r     <= v_phase_s;
        end
    end

    assign VGA_CLK     = pix_clk_r;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_BLANK_N = blank_n_r;
    assign VGA_HS      = hs_r;
    assign VGA_VS      = vs_r;
    assign VGA_R       = rgb_r[23:16];
    assign VGA_G       = rgb_r[15:8];
    assign VGA_B       = rgb_r[7:0];
    assign ohs         = ohs_r;
    assign ovs         = ovs_r;

endmodule

// File: tb/tb_vga_test_pattern.sv
// Scoreboard bench for vga_test_pattern. Horizontal timing is the standard
// 800-pixel line; the vertical axis is shortened to 11 lines
// (4 active, 2 front, 2 sync, 3 back) so whole frames fit in a short run.
module tb_vga_test_pattern;

    localparam int TV_ACTIVE = 4;
    localparam int TV_FP     = 2;
    localparam int TV_SYNC   = 2;
    localparam int TV_BP     = 3;
    localparam int TV_TOTAL  = 11;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank_n;
        logic [23:0] rgb;
        logic [2:0]  ohs;
        logic [2:0]  ovs;
    } out_t;

    typedef struct packed {
        int          hc;
        logic [23:0] rgb;
    } dir_t;

    localparam out_t RESET_OUT = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
                                   rgb: 24'h000000, ohs: 3'd0, ovs: 3'd0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_clk, vga_sync_n, vga_blank_n, vga_hs, vga_vs;
    logic [2:0] ohs, ovs;

    int checks = 0;
    int errors = 0;

    // model state (written only by the model process)
    int   cyc = 0;
    logic m_pix = 1'b0;
    int   m_hc = 0;
    int   m_vc = 0;
    int   m_frames = 0;

    out_t exp_q[$];
    dir_t dir_q[$];

    // measurement bookkeeping (written only by the monitor)
    int hs_first_n = 0, vs_first_n = 0, hs_per_n = 0, vs_per_n = 0, ohs_n = 0;

    always #10 clk = ~clk;

    vga_test_pattern #(
        .V_ACTIVE (TV_ACTIVE),
        .V_FP     (TV_FP),
        .V_SYNC   (TV_SYNC),
        .V_BP     (TV_BP)
    ) dut (
        .CLOCK_50    (clk),
        .RESET_N     (rst_n),
        .VGA_R       (vga_r),
        .VGA_G       (vga_g),
        .VGA_B       (vga_b),
        .VGA_CLK     (vga_clk),
        .VGA_SYNC_N  (vga_sync_n),
        .VGA_BLANK_N (vga_blank_n),
        .VGA_HS      (vga_hs),
        .VGA_VS      (vga_vs),
        .ohs         (ohs),
        .ovs         (ovs)
    );

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] colour(input int bar);
        case (bar)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic out_t expect_at(input int hc, input int vc);
        out_t o;
        o.ohs     = (hc < 640) ? 3'd0 : (hc < 656) ? 3'd1 : (hc < 752) ? 3'd2 : 3'd3;
        o.ovs     = (vc < 4)   ? 3'd0 : (vc < 6)   ? 3'd1 : (vc < 8)   ? 3'd2 : 3'd3;
        o.hs      = (o.ohs != 3'd2);
        o.vs      = (o.ovs != 3'd2);
        o.blank_n = (o.ohs == 3'd0) && (o.ovs == 3'd0);
        o.rgb     = o.blank_n ? colour(hc / 80) : 24'h000000;
        return o;
    endfunction

    function automatic out_t cur_out();
        return {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, ohs, ovs};
    endfunction

    // Reference model: on each pixel step push the expected outputs for the
    // position being registered, then advance the raster position
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                cyc = 0; m_pix = 1'b0; m_hc = 0; m_vc = 0;
            end else begin
                cyc++;
                if (m_pix) begin
                    exp_q.push_back(expect_at(m_hc, m_vc));
                    if (m_hc == 799) begin
                        m_hc = 0;
                        if (m_vc == TV_TOTAL - 1) begin
                            m_vc = 0;
                            m_frames++;
                        end else begin
                            m_vc++;
                        end
                    end else begin
                        m_hc++;
                    end
                end
                m_pix = ~m_pix;
            end
        end
    end

    // Monitor: compares on the falling edge, away from the active edge
    initial begin
        out_t act, e;
        dir_t d;
        logic prev_hs = 1'b1, prev_vs = 1'b1;
        logic [2:0] prev_ohs = 3'd0;
        logic hs_ok = 1'b0, vs_ok = 1'b0, ohs_ok = 1'b0, hs_pend = 1'b1, vs_pend = 1'b1;
        int hs_c = 0, vs_c = 0, ohs_c = 0, dur;
        forever begin
            @(negedge clk);
            act = cur_out();
            if (!rst_n) begin
                exp_q.delete();
                check("reset_outs", 40'(act), 40'(RESET_OUT));
                check("reset_vga_clk", 40'(vga_clk), 40'(1'b0));
                hs_ok = 1'b0; vs_ok = 1'b0; ohs_ok = 1'b0; hs_pend = 1'b1; vs_pend = 1'b1;
                prev_hs = 1'b1; prev_vs = 1'b1; prev_ohs = 3'd0;
            end else begin
                check("vga_clk", 40'(vga_clk), 40'(m_pix));
                check("sync_n", 40'(vga_sync_n), 40'(1'b0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("step_outs", 40'(act), 40'(e));
                end
                if (dir_q.size() > 0 && cyc == 2 * (dir_q[0].hc + 1)) begin
                    d = dir_q.pop_front();
                    check($sformatf("rgb_hc%0d", d.hc), 40'({vga_r, vga_g, vga_b}), 40'(d.rgb));
                end
                if (prev_hs && !vga_hs) begin
                    if (hs_pend) begin
                        check("hs_first_fall_cyc", 40'(cyc), 40'(1314));
                        hs_pend = 1'b0; hs_first_n++;
                    end
                    if (hs_ok) begin
                        check("hs_period", 40'(cyc - hs_c), 40'(1600));
                        hs_per_n++;
                    end
                    hs_c = cyc; hs_ok = 1'b1;
                end else if (!prev_hs && vga_hs && hs_ok) begin
                    check("hs_width", 40'(cyc - hs_c), 40'(192));
                end
                if (prev_vs && !vga_vs) begin
                    if (vs_pend) begin
                        check("vs_first_fall_cyc", 40'(cyc), 40'(9602));
                        vs_pend = 1'b0; vs_first_n++;
                    end
                    if (vs_ok) begin
                        check("vs_period", 40'(cyc - vs_c), 40'(17600));
                        vs_per_n++;
                    end
                    vs_c = cyc; vs_ok = 1'b1;
                end else if (!prev_vs && vga_vs && vs_ok) begin
                    check("vs_width", 40'(cyc - vs_c), 40'(3200));
                end
                if (ohs != prev_ohs) begin
                    if (ohs_ok) begin
                        case (prev_ohs)
                            3'd0:    dur = 1280;
                            3'd1:    dur = 32;
                            3'd2:    dur = 192;
                            3'd3:    dur = 96;
                            default: dur = 0;
                        endcase
                        check("ohs_duration", 40'(cyc - ohs_c), 40'(dur));
                        ohs_n++;
                    end
                    ohs_c = cyc; ohs_ok = 1'b1;
                end
                prev_hs = vga_hs; prev_vs = vga_vs; prev_ohs = ohs;
            end
        end
    end

    // Stimulus: reset, run, asynchronous reset mid-line, run again
    initial begin
        bit found;
        dir_q.push_back('{hc: 0,   rgb: 24'hFFFFFF});
        dir_q.push_back('{hc: 79,  rgb: 24'hFFFFFF});
        dir_q.push_back('{hc: 80,  rgb: 24'hFFFF00});
        dir_q.push_back('{hc: 160, rgb: 24'h00FFFF});
        dir_q.push_back('{hc: 400, rgb: 24'hFF0000});
        dir_q.push_back('{hc: 639, rgb: 24'h000000});
        dir_q.push_back('{hc: 640, rgb: 24'h000000});
        dir_q.push_back('{hc: 799, rgb: 24'h000000});

        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #5 rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 60000 && !found; i++) begin
            @(posedge clk);
            #3;
            if (m_frames >= 2 && m_vc == 2 && m_hc == 300) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_reset_point: not reached within cycle budget");
        end

        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 40'(cur_out()), 40'(RESET_OUT));
        check("async_reset_vga_clk", 40'(vga_clk), 40'(1'b0));
        repeat (4) @(posedge clk);
        @(negedge clk);
        #5 rst_n = 1'b1;

        repeat (10400) @(posedge clk);
        #1;
        check("hs_first_fall_count", 40'(hs_first_n), 40'(2));
        check("vs_first_fall_count", 40'(vs_first_n), 40'(2));
        check("hs_period_seen", 40'(hs_per_n > 10), 40'(1'b1));
        check("vs_period_seen", 40'(vs_per_n >= 1), 40'(1'b1));
        check("ohs_runs_seen", 40'(ohs_n >= 8), 40'(1'b1));
        check("directed_consumed", 40'(dir_q.size()), 40'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
